rr_grant_arbiter: RTL
=====================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter for up to 2^OUT_SIZE requesters. It sits directly upstream of the one-hot-to-binary encoder.
- Produces a registered one-hot grant vector (which drives the encoder's `in`) and the matching binary index, with a valid/ready handshake toward the consumer.
- The grant is held stable until accepted; priority then rotates past the last winner.

Parameters:
- OUT_SIZE, 4, width of the binary grant index.
- IN_SIZE, 1<<OUT_SIZE (localparam, not overridable), number of requesters and width of the one-hot grant.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  IN_SIZE  request lines, bit j = requester j. Level-sensitive.
- enable  input  1  when low, no new grant is issued; a grant already held is unaffected.
- gnt  output  IN_SIZE  registered one-hot grant. All-zero when no grant is held.
- gnt_idx  output  OUT_SIZE  binary index of the set bit in gnt. Equals the encoder output for gnt.
- gnt_valid  output  1  a grant is held.
- gnt_ready  input  1  consumer accepts the held grant this cycle.

Behaviour:

Reset (async assert, sync deassert handled upstream):
- gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, state=IDLE.
- Assertion mid-grant drops the grant immediately; no accept is recorded.

Internal state:
- ptr, OUT_SIZE bits: highest-priority requester index.
- FSM with states IDLE and BUSY. gnt_valid = (state==BUSY), registered.

Winner search (combinational, on current req):
- Winner = first j with req[j]=1, scanning ptr, ptr+1, …, IN_SIZE-1, 0, …, ptr-1 (modulo IN_SIZE).
- "none" if req==0.

IDLE:
- If enable=1 and a winner exists: at the next edge gnt<=onehot(winner), gnt_idx<=winner, state<=BUSY.
- Latency: a request seen at edge k gives gnt_valid high after edge k+1's register update, i.e. 1 cycle.
- Otherwise stay in IDLE with gnt=0.

BUSY:
- gnt and gnt_idx are held constant while gnt_ready=0. This holds even if req[gnt_idx] drops or enable falls; a grant is never withdrawn except by reset.
- Accept occurs on an edge with gnt_valid=1 and gnt_ready=1. At that edge:
  - ptr <= (gnt_idx+1) mod IN_SIZE. Wrap: idx IN_SIZE-1 gives ptr 0.
  - If enable=1 and a winner exists when searched from the new ptr value (computed in the same cycle from gnt_idx+1, not the stale ptr), load the new grant and stay in BUSY. This allows back-to-back grants, one per cycle.
  - Otherwise gnt<=0, gnt_idx<=0, state<=IDLE.
- The sole requester may win consecutively: after ptr rotates past it, the scan wraps back to it.

Invariants (checked in the bench):
- gnt is zero or one-hot (never multi-hot).
- gnt!=0 iff gnt_valid.
- gnt_idx == encoder(gnt).
- Starvation freedom: a continuously asserted request is granted within IN_SIZE accepts.

Arithmetic:
- All index math is modulo IN_SIZE, using OUT_SIZE-bit natural wrap. No other width growth.

Not supported:
- No request masking or weighting.
- No change of OUT_SIZE at runtime.

Test Plan:
- Reset: assert rst mid-BUSY with gnt=16'h0010 → gnt=0, gnt_valid=0, gnt_idx=0 immediately; after release with req=16'h0010, grant reissued 1 cycle later with ptr=0 semantics.
- Single request: req=16'h0100, gnt_ready=1 → gnt_valid rises 1 cycle after req; gnt=16'h0100, gnt_idx=8; re-granted every cycle while req held.
- Round-robin: req=16'h8421, gnt_ready=1 constantly → gnt_idx sequence 0,5,10,15,0,5,… on consecutive cycles with no gaps.
- Backpressure: req=16'h0006, gnt_ready=0 for 5 cycles, drop req[1] on cycle 2 → gnt stays 16'h0002, idx 1 for all 5 cycles; after accept, next gnt=16'h0004, idx 2.
- Wrap-around: ptr driven to 15 (accept idx 14), then req=16'h8001 → idx 15 granted first, then idx 0.
- Enable gating: enable=0 with req=16'hFFFF → gnt_valid stays 0. Grant already held when enable falls → completes on gnt_ready; state then returns to IDLE. Random req/ready for 10k cycles → invariants hold and no requester waits longer than 16 accepts.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grant plus binary index, held until accepted.
// One-cycle request-to-grant latency; back-to-back grants on accept.
module rr_grant_arbiter #(
  parameter  int OUT_SIZE = 4,
  localparam int IN_SIZE  = 1 << OUT_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_SIZE-1:0]  req,
  input  logic                enable,
  output logic [IN_SIZE-1:0]  gnt,
  output logic [OUT_SIZE-1:0] gnt_idx,
  output logic                gnt_valid,
  input  logic                gnt_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]          state;
  logic [OUT_SIZE-1:0] ptr;
  logic [OUT_SIZE-1:0] start;
  logic [OUT_SIZE-1:0] cand;
  logic [OUT_SIZE-1:0] win;
  logic                found;

  // On an accept the scan starts just past the current winner, not from the stale ptr,
  // so a back-to-back grant already reflects the rotation.
  always_comb begin
    start = (state == BUSY) ? gnt_idx + OUT_SIZE'(1) : ptr;
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int i = IN_SIZE - 1; i >= 0; i--) begin
      cand = start + OUT_SIZE'(i);
      if (req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && found) begin
            gnt     <= IN_SIZE'(1) << win;
            gnt_idx <= win;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (gnt_ready) begin
            ptr <= gnt_idx + OUT_SIZE'(1);
            if (enable && found) begin
              gnt     <= IN_SIZE'(1) << win;
              gnt_idx <= win;
            end else begin
              gnt     <= '0;
              gnt_idx <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_valid = (state == BUSY);

endmodule
